// File: rtl/core_id_q_if.sv
// core_id_q_if: IF-to-ID fetch handshake (valid/ready with pc and instruction)
interface core_id_q_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    modport master (output if_valid, if_pc, if_instr, input if_ready);
    modport slave  (input if_valid, if_pc, if_instr, output if_ready);
endinterface

// File: rtl/core_id_q.sv
// core_id_q: decode stage with instruction queue, ID register and combinational decode
module core_id_q #(
    parameter int DEPTH    = 4,
    parameter int NUM_WB   = 2,
    parameter int IMM_BITS = 11,
    parameter int FSEL_W   = $clog2(NUM_WB + 3)
) (
    input  logic                clk,
    input  logic                rst,
    core_id_q_if.slave          fe,
    input  logic                id_halt,
    input  logic                id_flush,
    input  logic [NUM_WB-1:0]   wb_en,
    input  logic [NUM_WB*4-1:0] wb_addr,
    input  logic [2:0]          flag,
    output logic                id_valid,
    output logic [31:0]         id_pc,
    output logic [31:0]         id_instr,
    output logic [3:0]          rega_addr,
    output logic [3:0]          regb_addr,
    output logic [FSEL_W-1:0]   fwd_a_sel,
    output logic [FSEL_W-1:0]   fwd_b_sel,
    output logic [31:0]         imm,
    output logic                branch,
    output logic                branch_imm,
    output logic                branch_abs,
    output logic                swi,
    output logic                rfe,
    output logic                wb_spr,
    output logic [3:0]          spr_addr,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);
    // instruction layout: opcode[31:26] i[25] s[24] regd_cond[23:20] rega[19:16] regb[15:12] imm[IMM_BITS-1:0]
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [5:0] OPCODE_NOP  = 6'h00;
    localparam logic [5:0] OPCODE_B    = 6'h04;
    localparam logic [5:0] OPCODE_CALL = 6'h05;
    localparam logic [5:0] OPCODE_RET  = 6'h06;
    localparam logic [5:0] OPCODE_SWI  = 6'h08;
    localparam logic [5:0] OPCODE_RFE  = 6'h09;
    localparam logic [5:0] OPCODE_MOV  = 6'h10;
    localparam logic [3:0] RF_PC       = 4'hF;

    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, adv, pop, bypass, store;
    logic [5:0]    op;
    logic          is_i, is_s;
    logic [3:0]    rd;

    assign fe.if_ready = q_count < CW'(DEPTH);
    assign push   = fe.if_valid && fe.if_ready && !id_flush;
    assign adv    = !id_halt && !id_flush;
    assign pop    = adv && q_count != '0;
    assign bypass = adv && q_count == '0 && push;
    assign store  = push && !bypass;

    // queue pointers, occupancy and ID pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= {OPCODE_NOP, 26'(0)};
        end else if (id_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            id_valid <= 1'b0;
            id_instr <= {OPCODE_NOP, 26'(1)};
        end else begin
            wr_ptr  <= store ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr  <= pop ? rd_ptr + PW'(1) : rd_ptr;
            q_count <= q_count + CW'(store) - CW'(pop);
            if (adv) begin
                id_valid <= pop || bypass;
                id_pc    <= pop ? mem_pc[rd_ptr] : bypass ? fe.if_pc : id_pc;
                id_instr <= pop ? mem_instr[rd_ptr] : bypass ? fe.if_instr : {OPCODE_NOP, 26'(0)};
            end
        end
    end

    // queue storage needs no reset: occupancy guards every read
    always_ff @(posedge clk) begin
        if (store) begin
            mem_pc[wr_ptr]    <= fe.if_pc;
            mem_instr[wr_ptr] <= fe.if_instr;
        end
    end

    assign op        = id_instr[31:26];
    assign is_i      = id_instr[25];
    assign is_s      = id_instr[24];
    assign rd        = id_instr[23:20];
    assign rega_addr = id_instr[19:16];
    assign regb_addr = id_instr[15:12];
    assign spr_addr  = rd;

    // decode, all results gated by id_valid; lowest writeback port wins by being applied last
    always_comb begin
        fwd_a_sel = rega_addr == RF_PC ? FSEL_W'(1) : '0;
        fwd_b_sel = regb_addr == RF_PC ? FSEL_W'(1) : '0;
        for (int k = NUM_WB - 1; k >= 0; k--) begin
            fwd_a_sel = wb_en[k] && wb_addr[k*4 +: 4] == rega_addr ? FSEL_W'(2 + k) : fwd_a_sel;
            fwd_b_sel = wb_en[k] && wb_addr[k*4 +: 4] == regb_addr ? FSEL_W'(3 + k) : fwd_b_sel;
        end
        fwd_b_sel  = is_i ? FSEL_W'(2) : fwd_b_sel;
        fwd_a_sel  = id_valid ? fwd_a_sel : '0;
        fwd_b_sel  = id_valid ? fwd_b_sel : '0;
        imm        = id_valid && is_i ? {{(32-IMM_BITS){is_s & id_instr[IMM_BITS-1]}}, id_instr[IMM_BITS-1:0]} : '0;
        branch     = id_valid && ((op == OPCODE_B && rd[2:0] == flag) || op == OPCODE_CALL || op == OPCODE_RET);
        branch_imm = id_valid && is_i;
        branch_abs = id_valid && regb_addr[0];
        swi        = id_valid && op == OPCODE_SWI;
        rfe        = id_valid && op == OPCODE_RFE;
        wb_spr     = id_valid && op == OPCODE_MOV && regb_addr[1];
    end
endmodule

// File: tb/tb_core_id_q.sv
// tb_core_id_q: directed vector and sequence checks for the decode stage
module tb_core_id_q;
    localparam logic [5:0] NOP = 6'h00, ADD = 6'h01, B = 6'h04, CALL = 6'h05, RET = 6'h06;
    localparam logic [5:0] SWI = 6'h08, RFE = 6'h09, MOV = 6'h10;

    logic        clk = 0, rst = 0;
    logic        id_halt = 0, id_flush = 0;
    logic [1:0]  wb_en = 0;
    logic [7:0]  wb_addr = 0;
    logic [2:0]  flag = 0;
    logic        id_valid, branch, branch_imm, branch_abs, swi, rfe, wb_spr;
    logic [31:0] id_pc, id_instr, imm;
    logic [3:0]  rega_addr, regb_addr, spr_addr;
    logic [2:0]  fwd_a_sel, fwd_b_sel, q_count;
    int compared = 0, mismatched = 0;

    core_id_q_if fe();

    core_id_q dut (
        .clk(clk), .rst(rst), .fe(fe), .id_halt(id_halt), .id_flush(id_flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .flag(flag), .id_valid(id_valid), .id_pc(id_pc),
        .id_instr(id_instr), .rega_addr(rega_addr), .regb_addr(regb_addr),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .imm(imm), .branch(branch),
        .branch_imm(branch_imm), .branch_abs(branch_abs), .swi(swi), .rfe(rfe),
        .wb_spr(wb_spr), .spr_addr(spr_addr), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  wb_en;
        logic [7:0]  wb_addr;
        logic [2:0]  flag;
        logic [31:0] imm;
        logic [2:0]  fa;
        logic [2:0]  fb;
        logic [5:0]  flg;
        logic [3:0]  spr;
    } vec_t;

    function automatic logic [31:0] mk(logic [5:0] op, logic i, logic s, logic [3:0] rd,
                                       logic [3:0] ra, logic [3:0] rb, logic [10:0] im);
        return {op, i, s, rd, ra, rb, 1'b0, im};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [31:0] pc, logic [31:0] instr);
        fe.if_valid = 1;
        fe.if_pc    = pc;
        fe.if_instr = instr;
    endtask

    vec_t v[16];

    initial begin
        fe.if_valid = 0;
        fe.if_pc    = 0;
        fe.if_instr = 0;
        v[0]  = '{mk(ADD,0,0,0,5,5,0),        2'b11, 8'h55, 0, 32'h0,        3'd2, 3'd3, 6'b001000, 4'd0};
        v[1]  = '{mk(ADD,0,0,0,5,5,0),        2'b10, 8'h55, 0, 32'h0,        3'd3, 3'd4, 6'b001000, 4'd0};
        v[2]  = '{mk(ADD,0,0,0,15,15,0),      2'b00, 8'h00, 0, 32'h0,        3'd1, 3'd1, 6'b001000, 4'd0};
        v[3]  = '{mk(ADD,1,1,0,5,5,11'h7FF),  2'b11, 8'h55, 0, 32'hFFFFFFFF, 3'd2, 3'd2, 6'b011000, 4'd0};
        v[4]  = '{mk(ADD,1,0,0,5,4,11'h7FF),  2'b00, 8'h00, 0, 32'h000007FF, 3'd0, 3'd2, 6'b010000, 4'd0};
        v[5]  = '{mk(ADD,1,1,0,0,0,11'h400),  2'b00, 8'h00, 0, 32'hFFFFFC00, 3'd0, 3'd2, 6'b010000, 4'd0};
        v[6]  = '{mk(ADD,1,1,0,0,0,11'h3FF),  2'b00, 8'h00, 0, 32'h000003FF, 3'd0, 3'd2, 6'b010000, 4'd0};
        v[7]  = '{mk(B,0,0,4'd2,0,0,0),       2'b00, 8'h00, 3'b010, 32'h0,   3'd0, 3'd0, 6'b100000, 4'd2};
        v[8]  = '{mk(B,0,0,4'd2,0,0,0),       2'b00, 8'h00, 3'b011, 32'h0,   3'd0, 3'd0, 6'b000000, 4'd2};
        v[9]  = '{mk(B,0,0,4'hA,0,0,0),       2'b00, 8'h00, 3'b010, 32'h0,   3'd0, 3'd0, 6'b100000, 4'hA};
        v[10] = '{mk(CALL,0,0,0,0,1,0),       2'b00, 8'h00, 0, 32'h0,        3'd0, 3'd0, 6'b101000, 4'd0};
        v[11] = '{mk(RET,1,0,0,0,0,0),        2'b00, 8'h00, 0, 32'h0,        3'd0, 3'd2, 6'b110000, 4'd0};
        v[12] = '{mk(SWI,0,0,0,0,0,0),        2'b00, 8'h00, 0, 32'h0,        3'd0, 3'd0, 6'b000100, 4'd0};
        v[13] = '{mk(RFE,0,0,0,0,0,0),        2'b00, 8'h00, 0, 32'h0,        3'd0, 3'd0, 6'b000010, 4'd0};
        v[14] = '{mk(MOV,0,0,7,3,2,0),        2'b01, 8'h03, 0, 32'h0,        3'd2, 3'd0, 6'b000001, 4'd7};
        v[15] = '{mk(MOV,0,0,7,3,1,0),        2'b00, 8'h00, 0, 32'h0,        3'd0, 3'd0, 6'b001000, 4'd7};

        tick();
        tick();
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_pc", id_pc, 0);
        chk("rst_instr", id_instr, 0);
        chk("rst_count", 32'(q_count), 0);
        chk("rst_ready", 32'(fe.if_ready), 1);
        chk("rst_flags", {branch, branch_imm, branch_abs, swi, rfe, wb_spr, fwd_a_sel, fwd_b_sel}, 0);
        chk("rst_imm", imm, 0);
        rst = 1;
        tick();

        push(32'h100, mk(ADD,0,0,0,1,2,0));
        tick();
        fe.if_valid = 0;
        chk("byp_valid", 32'(id_valid), 1);
        chk("byp_pc", id_pc, 32'h100);
        chk("byp_count", 32'(q_count), 0);
        tick();
        chk("idle_valid", 32'(id_valid), 0);
        chk("idle_pc_hold", id_pc, 32'h100);
        chk("idle_instr", id_instr, 0);

        id_halt = 1;
        for (int i = 0; i < 5; i++) begin
            push(32'h200 + 32'(i * 4), mk(ADD,0,0,0,0,0,11'(i)));
            tick();
            if (i == 3) chk("fill_ready_low", 32'(fe.if_ready), 0);
        end
        fe.if_valid = 0;
        chk("fill_count", 32'(q_count), 4);
        chk("halt_valid_hold", 32'(id_valid), 0);
        id_halt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_pc", id_pc, 32'h200 + 32'(i * 4));
            chk("drain_valid", 32'(id_valid), 1);
            chk("drain_ready", 32'(fe.if_ready), 1);
        end
        tick();
        chk("drain_empty_valid", 32'(id_valid), 0);
        chk("drain_empty_count", 32'(q_count), 0);

        id_halt = 1;
        for (int i = 0; i < 3; i++) begin
            push(32'h300 + 32'(i * 4), 0);
            tick();
        end
        chk("pre_flush_count", 32'(q_count), 3);
        push(32'h3F0, 0);
        id_flush = 1;
        tick();
        id_flush = 0;
        fe.if_valid = 0;
        chk("flush_count", 32'(q_count), 0);
        chk("flush_instr", id_instr, 32'h1);
        chk("flush_valid", 32'(id_valid), 0);
        chk("flush_ready", 32'(fe.if_ready), 1);
        id_halt = 0;
        tick();
        chk("flush_drop_valid", 32'(id_valid), 0);
        chk("flush_drop_pc", id_pc, 32'h20C);

        id_halt = 1;
        push(32'h400, 0);
        tick();
        push(32'h404, 0);
        tick();
        id_halt = 0;
        push(32'h408, 0);
        tick();
        chk("pushpop_count", 32'(q_count), 2);
        chk("pushpop_pc", id_pc, 32'h400);
        fe.if_valid = 0;
        #2 rst = 0;
        #1;
        chk("arst_count", 32'(q_count), 0);
        chk("arst_valid", 32'(id_valid), 0);
        chk("arst_instr", id_instr, 0);
        chk("arst_pc", id_pc, 0);
        @(posedge clk);
        #1 rst = 1;
        tick();

        for (int i = 0; i < 16; i++) begin
            wb_en   = v[i].wb_en;
            wb_addr = v[i].wb_addr;
            flag    = v[i].flag;
            push(32'h1000 + 32'(i * 4), v[i].instr);
            tick();
            fe.if_valid = 0;
            chk($sformatf("v%0d_valid", i), 32'(id_valid), 1);
            chk($sformatf("v%0d_imm", i), imm, v[i].imm);
            chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a_sel), 32'(v[i].fa));
            chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b_sel), 32'(v[i].fb));
            chk($sformatf("v%0d_flags", i), 32'({branch, branch_imm, branch_abs, swi, rfe, wb_spr}), 32'(v[i].flg));
            chk($sformatf("v%0d_spr", i), 32'(spr_addr), 32'(v[i].spr));
        end

        flag = 3'b010;
        push(32'h2000, mk(B,0,0,4'd2,0,0,0));
        tick();
        fe.if_valid = 0;
        chk("br_valid_taken", 32'(branch), 1);
        tick();
        chk("br_invalid_gate", 32'(branch), 0);
        chk("br_invalid_valid", 32'(id_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
